// File: rtl/fp_subtractor.sv
// fp_subtractor: multi-cycle IEEE-754 single-precision subtractor, result = a - b.
// The subtrahend's sign is flipped on capture and the operation becomes an addition.
// Alignment and normalisation shift one bit per cycle under a small FSM.
// The datapath mantissa is 28 bits: carry, implicit bit, 23 fraction bits, then G/R/S.
// Optional feature: define FP_SUB_RNE_EN for round-to-nearest-even in PACK.
// Without it, PACK truncates.
// Specials are resolved in UNPACK. They pass through PACK only to register the
// result, so that they meet the two-cycle special latency.
module fp_subtractor (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_UNPACK = 3'd1,
      S_ALIGN  = 3'd2,
      S_ADD    = 3'd3,
      S_NORM   = 3'd4,
      S_PACK   = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [31:0] r_a;
   logic [31:0] r_b;            // already negated subtrahend
   logic        r_sx;
   logic        r_sy;
   logic [9:0]  r_ex;
   logic [27:0] r_mx;
   logic [27:0] r_my;
   logic [4:0]  r_cnt;
   logic        r_special;
   logic [31:0] r_special_val;
   logic [31:0] r_result;
   logic        r_out_valid;

   // A further left shift is needed while the implicit bit is clear, the exponent can still drop, and m is nonzero
   function automatic logic f_need_norm(input logic [27:0] m, input logic [9:0] e);
      return (m[26] == 1'b0) && (e > 10'd1) && (m != 28'd0);
   endfunction

   // ---------------- UNPACK decode ----------------
   logic [7:0]  w_ea, w_eb, w_ex, w_ey, w_diff;
   logic [27:0] w_ma, w_mb, w_mx, w_my;
   logic        w_a_ge_b, w_sx, w_sy;
   logic [4:0]  w_shift;
   logic        w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_special;
   logic [31:0] w_special_val;

   // Unpack both operands: denormals use exponent 1 with a clear implicit bit
   always_comb begin
      w_ea     = (r_a[30:23] == 8'd0) ? 8'd1 : r_a[30:23];
      w_eb     = (r_b[30:23] == 8'd0) ? 8'd1 : r_b[30:23];
      w_ma     = {1'b0, |r_a[30:23], r_a[22:0], 3'b000};
      w_mb     = {1'b0, |r_b[30:23], r_b[22:0], 3'b000};
      // The raw magnitude bits order the same way as the values themselves
      w_a_ge_b = (r_a[30:0] >= r_b[30:0]);
      w_sx     = w_a_ge_b ? r_a[31] : r_b[31];
      w_sy     = w_a_ge_b ? r_b[31] : r_a[31];
      w_ex     = w_a_ge_b ? w_ea : w_eb;
      w_ey     = w_a_ge_b ? w_eb : w_ea;
      w_mx     = w_a_ge_b ? w_ma : w_mb;
      w_my     = w_a_ge_b ? w_mb : w_ma;
      w_diff   = w_ex - w_ey;
      w_shift  = (w_diff > 8'd26) ? 5'd26 : w_diff[4:0];

      w_a_inf  = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
      w_b_inf  = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
      w_a_nan  = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
      w_b_nan  = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
      w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf;
      // Opposite signs after negation means Inf minus a same-signed Inf
      if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (r_a[31] != r_b[31])))
         w_special_val = 32'h7FC0_0000;
      else if (w_a_inf)
         w_special_val = r_a;
      else
         w_special_val = r_b;
   end

   // ---------------- ADD / NORM ----------------
   logic [27:0] w_sum, w_add_m, w_shl_m;
   logic [9:0]  w_add_e, w_shl_e;

   // Add or subtract the aligned mantissas; a carry is folded back with sticky kept
   always_comb begin
      w_sum   = (r_sx == r_sy) ? (r_mx + r_my) : (r_mx - r_my);
      w_add_m = w_sum[27] ? {1'b0, w_sum[27:2], w_sum[1] | w_sum[0]} : w_sum;
      w_add_e = r_ex + {9'd0, w_sum[27]};
      w_shl_m = {r_mx[26:0], 1'b0};
      w_shl_e = r_ex - 10'd1;
   end

   // ---------------- PACK ----------------
   logic        w_inc;
   logic [24:0] w_rnd;
   logic [22:0] w_frac;
   logic [9:0]  w_e_fin;
   logic        w_hid;
   logic [31:0] w_pack;

   // Round the 24-bit significand, then encode zero, overflow, denormal or normal
   always_comb begin
`ifdef FP_SUB_RNE_EN
      w_inc = r_mx[2] & (r_mx[1] | r_mx[0] | r_mx[3]);
`else
      w_inc = 1'b0;
`endif
      w_rnd   = {1'b0, r_mx[26:3]} + {24'd0, w_inc};
      w_frac  = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
      w_e_fin = r_ex + {9'd0, w_rnd[24]};
      w_hid   = w_rnd[24] | w_rnd[23];
      if (r_mx == 28'd0)
         w_pack = {r_sx & r_sy, 31'd0};           // -0 only for (-0)-(+0)
      else if (w_e_fin >= 10'd255)
         w_pack = {r_sx, 8'hFF, 23'd0};
      else if (!w_hid)
         w_pack = {r_sx, 8'h00, w_frac};
      else
         w_pack = {r_sx, w_e_fin[7:0], w_frac};
   end

   // ---------------- FSM ----------------
   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   // Next-state decision; ADD and NORM look ahead so that no idle NORM cycle is spent
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (in_valid) w_next_state = S_UNPACK;
         S_UNPACK: begin
            if (w_special)
               w_next_state = S_PACK;
            else if (w_shift != 5'd0)
               w_next_state = S_ALIGN;
            else
               w_next_state = S_ADD;
         end
         S_ALIGN:  if (r_cnt == 5'd1) w_next_state = S_ADD;
         S_ADD:    w_next_state = f_need_norm(w_add_m, w_add_e) ? S_NORM : S_PACK;
         S_NORM:   w_next_state = f_need_norm(w_shl_m, w_shl_e) ? S_NORM : S_PACK;
         S_PACK:   w_next_state = S_DONE;
         S_DONE:   if (out_ready) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Handshake outputs derived from the state
   always_comb begin
      in_ready  = (r_state == S_IDLE);
      busy      = (r_state != S_IDLE);
      out_valid = r_out_valid;
      result    = r_result;
   end

   // Datapath registers stepped by the current state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a           <= 32'd0;
         r_b           <= 32'd0;
         r_sx          <= 1'b0;
         r_sy          <= 1'b0;
         r_ex          <= 10'd0;
         r_mx          <= 28'd0;
         r_my          <= 28'd0;
         r_cnt         <= 5'd0;
         r_special     <= 1'b0;
         r_special_val <= 32'd0;
         r_result      <= 32'd0;
         r_out_valid   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a <= a;
                  r_b <= b ^ 32'h8000_0000;
               end
            end
            S_UNPACK: begin
               r_sx          <= w_sx;
               r_sy          <= w_sy;
               r_ex          <= {2'b00, w_ex};
               r_mx          <= w_mx;
               r_my          <= w_my;
               r_cnt         <= w_shift;
               r_special     <= w_special;
               r_special_val <= w_special_val;
            end
            S_ALIGN: begin
               r_my  <= {1'b0, r_my[27:2], r_my[1] | r_my[0]};
               r_cnt <= r_cnt - 5'd1;
            end
            S_ADD: begin
               r_mx <= w_add_m;
               r_ex <= w_add_e;
            end
            S_NORM: begin
               r_mx <= w_shl_m;
               r_ex <= w_shl_e;
            end
            S_PACK: begin
               r_result    <= r_special ? r_special_val : w_pack;
               r_out_valid <= 1'b1;
            end
            S_DONE: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
